// File: rtl/smart_viol_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : smart_viol_ctrl
//  Purpose  : Converts each violation level coming from smart_mac into a
//             clean, fixed-length system reset pulse.  It logs the first
//             unacknowledged violation (address + PC), flags overflow when a
//             new violation arrives before the log is acknowledged, and keeps
//             a saturating count of violations since power-on reset.
//  Config   : SMART_VIOL_LOCK_EN - when defined, the violation that brings the
//             count to MAX_VIOL enters a permanent LOCK state (sys_rst and
//             locked held high until puc_rst).  When undefined, there is no
//             LOCK state, locked is tied low and MAX_VIOL is unused.
//  Ports    :
//    mclk          in   clock, rising edge
//    puc_rst       in   async active-high power-on reset
//    viol_req      in   violation level from smart_mac
//    viol_addr     in   mem_addr at time of violation
//    viol_pc       in   ins_addr at time of violation
//    disable_debug in   ignore new violations, abort a running pulse
//    log_ack       in   one-cycle pulse clearing viol_valid / viol_ovf
//    sys_rst       out  registered system reset pulse
//    viol_valid    out  log holds an unacknowledged violation
//    viol_ovf      out  sticky: violation while viol_valid was set
//    viol_addr_q   out  logged address
//    viol_pc_q     out  logged PC
//    viol_cnt      out  saturating violation count
//    locked        out  permanent lock active
//  Revision : 1.0 - initial release
// ============================================================================
module smart_viol_ctrl #(
    parameter int SIZE_MEM_ADDR = 15,
    parameter int RST_CYCLES    = 16,
    parameter int DRAIN_CYCLES  = 4,
    parameter int CNT_W         = 8,
    parameter int MAX_VIOL      = 3
) (
    input  logic                     mclk,
    input  logic                     puc_rst,
    input  logic                     viol_req,
    input  logic [SIZE_MEM_ADDR:0]   viol_addr,
    input  logic [15:0]              viol_pc,
    input  logic                     disable_debug,
    input  logic                     log_ack,
    output logic                     sys_rst,
    output logic                     viol_valid,
    output logic                     viol_ovf,
    output logic [SIZE_MEM_ADDR:0]   viol_addr_q,
    output logic [15:0]              viol_pc_q,
    output logic [CNT_W-1:0]         viol_cnt,
    output logic                     locked
);

    // Timer only ever holds RST_CYCLES-1 or DRAIN_CYCLES-1, so clog2 of the
    // larger count is enough; keep at least one bit.
    localparam int TMAX = (RST_CYCLES > DRAIN_CYCLES) ? RST_CYCLES : DRAIN_CYCLES;
    localparam int TW   = (TMAX > 1) ? $clog2(TMAX) : 1;

    localparam logic [TW-1:0] RST_LOAD   = TW'(RST_CYCLES - 1);
    localparam logic [TW-1:0] DRAIN_LOAD = TW'(DRAIN_CYCLES - 1);

`ifdef SMART_VIOL_LOCK_EN
    localparam logic [CNT_W-1:0] LOCK_AT = CNT_W'(MAX_VIOL);
`endif

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_HOLD  = 2'd1,
        ST_DRAIN = 2'd2,
        ST_LOCK  = 2'd3
    } state_t;

    state_t                   state_q;
    logic [TW-1:0]            timer_q;
    logic                     sys_rst_q;
    logic                     valid_q;
    logic                     ovf_q;
    logic [SIZE_MEM_ADDR:0]   addr_q;
    logic [15:0]              pc_q;
    logic [CNT_W-1:0]         cnt_q;
    logic [CNT_W-1:0]         cnt_d;
    logic                     viol_trig;
    logic                     capture;

    // A violation is only accepted while armed in IDLE.
    assign viol_trig = (state_q == ST_IDLE) & viol_req & ~disable_debug;

    // Log is free when empty, or when it is being acknowledged this edge.
    assign capture   = ~valid_q | log_ack;

    // Saturating increment: hold at all-ones.
    assign cnt_d     = (&cnt_q) ? cnt_q : (cnt_q + CNT_W'(1));

`ifdef SMART_VIOL_LOCK_EN
    logic locked_q;
    assign locked = locked_q;
`else
    assign locked = 1'b0;
`endif

    always_ff @(posedge mclk or posedge puc_rst) begin
        if (puc_rst) begin
            state_q   <= ST_IDLE;
            timer_q   <= '0;
            sys_rst_q <= 1'b0;
            valid_q   <= 1'b0;
            ovf_q     <= 1'b0;
            addr_q    <= '0;
            pc_q      <= '0;
            cnt_q     <= '0;
`ifdef SMART_VIOL_LOCK_EN
            locked_q  <= 1'b0;
`endif
        end else begin
            // Logging runs independently of the pulse sequencing so that
            // acknowledge works in every state, including LOCK.
            if (viol_trig) begin
                if (capture) begin
                    addr_q  <= viol_addr;
                    pc_q    <= viol_pc;
                    valid_q <= 1'b1;
                    ovf_q   <= 1'b0;
                end else begin
                    ovf_q   <= 1'b1;
                end
            end else if (log_ack) begin
                valid_q <= 1'b0;
                ovf_q   <= 1'b0;
            end

            case (state_q)
                ST_IDLE: begin
                    if (viol_trig) begin
                        cnt_q     <= cnt_d;
                        sys_rst_q <= 1'b1;
                        timer_q   <= RST_LOAD;
`ifdef SMART_VIOL_LOCK_EN
                        if (cnt_d == LOCK_AT) begin
                            state_q  <= ST_LOCK;
                            locked_q <= 1'b1;
                        end else begin
                            state_q  <= ST_HOLD;
                        end
`else
                        state_q   <= ST_HOLD;
`endif
                    end
                end

                ST_HOLD: begin
                    // Abort on disable_debug, otherwise release after the
                    // timer has counted the full pulse length.
                    if (disable_debug || (timer_q == '0)) begin
                        sys_rst_q <= 1'b0;
                        state_q   <= ST_DRAIN;
                        timer_q   <= DRAIN_LOAD;
                    end else begin
                        timer_q   <= timer_q - TW'(1);
                    end
                end

                ST_DRAIN: begin
                    // Re-arm only once quiet time is over and the violation
                    // level has dropped; a stuck-high request stays here.
                    if (timer_q == '0) begin
                        if (!viol_req) begin
                            state_q <= ST_IDLE;
                        end
                    end else begin
                        timer_q <= timer_q - TW'(1);
                    end
                end

                default: begin
`ifdef SMART_VIOL_LOCK_EN
                    // LOCK: only puc_rst leaves this state.
                    sys_rst_q <= 1'b1;
`else
                    state_q   <= ST_IDLE;
                    sys_rst_q <= 1'b0;
`endif
                end
            endcase
        end
    end

    assign sys_rst     = sys_rst_q;
    assign viol_valid  = valid_q;
    assign viol_ovf    = ovf_q;
    assign viol_addr_q = addr_q;
    assign viol_pc_q   = pc_q;
    assign viol_cnt    = cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_smart_viol_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_smart_viol_ctrl
//  Purpose  : Self-checking bench for smart_viol_ctrl: directed scenarios plus
//             randomized stimulus compared against a behavioural model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_smart_viol_ctrl;

    localparam int AW    = 16;
    localparam int RSTC  = 16;
    localparam int DRNC  = 4;
    localparam int CNTW  = 8;
    localparam int MAXV  = 3;
    localparam int MAXC  = (1 << CNTW) - 1;

    logic            mclk = 1'b0;
    logic            puc_rst;
    logic            tb_req;
    logic [AW-1:0]   tb_addr;
    logic [15:0]     tb_pc;
    logic            tb_dd;
    logic            tb_ack;
    logic            sys_rst;
    logic            viol_valid;
    logic            viol_ovf;
    logic [AW-1:0]   viol_addr_q;
    logic [15:0]     viol_pc_q;
    logic [CNTW-1:0] viol_cnt;
    logic            locked;

    int checks   = 0;
    int failures = 0;

    smart_viol_ctrl #(
        .SIZE_MEM_ADDR (AW - 1),
        .RST_CYCLES    (RSTC),
        .DRAIN_CYCLES  (DRNC),
        .CNT_W         (CNTW),
        .MAX_VIOL      (MAXV)
    ) dut (
        .mclk          (mclk),
        .puc_rst       (puc_rst),
        .viol_req      (tb_req),
        .viol_addr     (tb_addr),
        .viol_pc       (tb_pc),
        .disable_debug (tb_dd),
        .log_ack       (tb_ack),
        .sys_rst       (sys_rst),
        .viol_valid    (viol_valid),
        .viol_ovf      (viol_ovf),
        .viol_addr_q   (viol_addr_q),
        .viol_pc_q     (viol_pc_q),
        .viol_cnt      (viol_cnt),
        .locked        (locked)
    );

    always #5 mclk = ~mclk;

    // ------------------------------------------------------------------
    // Behavioural model. Phase: 0 armed, 1 pulsing, 2 quiet, 3 locked.
    // Pulse and quiet time are tracked as elapsed-edge counts.
    // ------------------------------------------------------------------
    int            m_phase;
    int            m_pulse_edges;
    int            m_quiet_edges;
    bit            m_sys;
    bit            m_valid;
    bit            m_ovf;
    bit [AW-1:0]   m_addr;
    bit [15:0]     m_pc;
    int            m_cnt;
    bit            m_locked;

    task automatic model_reset();
        m_phase = 0; m_pulse_edges = 0; m_quiet_edges = 0;
        m_sys = 0; m_valid = 0; m_ovf = 0; m_addr = '0; m_pc = '0;
        m_cnt = 0; m_locked = 0;
    endtask

    task automatic model_update();
        bit accept;
        accept = (m_phase == 0) && tb_req && !tb_dd;
        if (accept) begin
            if (!m_valid || tb_ack) begin
                m_addr = tb_addr; m_pc = tb_pc; m_valid = 1; m_ovf = 0;
            end else begin
                m_ovf = 1;
            end
        end else if (tb_ack) begin
            m_valid = 0; m_ovf = 0;
        end
        case (m_phase)
            0: if (accept) begin
                if (m_cnt < MAXC) m_cnt = m_cnt + 1;
                m_sys = 1;
`ifdef SMART_VIOL_LOCK_EN
                if (m_cnt == MAXV) begin m_phase = 3; m_locked = 1; end
                else begin m_phase = 1; m_pulse_edges = 0; end
`else
                m_phase = 1; m_pulse_edges = 0;
`endif
            end
            1: begin
                m_pulse_edges = m_pulse_edges + 1;
                if (tb_dd || m_pulse_edges == RSTC) begin
                    m_sys = 0; m_phase = 2; m_quiet_edges = 0;
                end
            end
            2: begin
                m_quiet_edges = m_quiet_edges + 1;
                if (m_quiet_edges >= DRNC && !tb_req) m_phase = 0;
            end
            default: m_sys = 1;
        endcase
    endtask

    task automatic step();
        @(posedge mclk);
        model_update();
        #1;
    endtask

    task automatic do_reset();
        tb_req = 0; tb_dd = 0; tb_ack = 0; tb_addr = '0; tb_pc = '0;
        puc_rst = 1;
        @(posedge mclk);
        #1;
        model_reset();
        puc_rst = 0;
    endtask

    task automatic wait_rearm();
        int n;
        n = 0;
        while (m_phase != 0 && n < 200) begin step(); n++; end
        checks++;
        if (m_phase != 0) begin
            failures++;
            $display("FAIL rearm_timeout: still waiting after %0d cycles, required <200", n);
        end
    endtask

    // ------------------------------------------------------------------
    task automatic test_reset();
        tb_req = 0; tb_dd = 0; tb_ack = 0; tb_addr = '0; tb_pc = '0;
        puc_rst = 1;
        #3;
        checks++;
        if ({sys_rst, viol_valid, viol_ovf, viol_addr_q, viol_pc_q, viol_cnt, locked} !== '0) begin
            failures++;
            $display("FAIL reset_state: got %b %b %b %h %h %h %b, required all zero",
                     sys_rst, viol_valid, viol_ovf, viol_addr_q, viol_pc_q, viol_cnt, locked);
        end
        @(posedge mclk); #1;
        model_reset();
        puc_rst = 0;
        repeat (3) step();
        checks++;
        if (sys_rst !== 1'b0) begin
            failures++;
            $display("FAIL idle_quiet: sys_rst=%b required 0", sys_rst);
        end
    endtask

    task automatic test_single();
        int hi;
        do_reset();
        tb_req = 1; tb_addr = 16'h00C8; tb_pc = 16'hE010;
        step();
        tb_req = 0;
        checks++;
        if (sys_rst !== 1'b1) begin
            failures++; $display("FAIL single_latency: sys_rst=%b required 1", sys_rst);
        end
        hi = (sys_rst === 1'b1) ? 1 : 0;
        repeat (30) begin step(); if (sys_rst === 1'b1) hi++; end
        checks++;
        if (hi != RSTC) begin
            failures++; $display("FAIL single_width: high cycles=%0d required %0d", hi, RSTC);
        end
        checks++;
        if ({viol_valid, viol_ovf, viol_addr_q, viol_pc_q, viol_cnt} !== {1'b1, 1'b0, 16'h00C8, 16'hE010, 8'd1}) begin
            failures++;
            $display("FAIL single_log: valid=%b ovf=%b addr=%h pc=%h cnt=%0d required 1 0 00c8 e010 1",
                     viol_valid, viol_ovf, viol_addr_q, viol_pc_q, viol_cnt);
        end
    endtask

    task automatic test_overflow_ack();
        wait_rearm();
        tb_req = 1; tb_addr = 16'h1234; tb_pc = 16'hBEEF;
        step();
        tb_req = 0;
        checks++;
        if ({sys_rst, viol_valid, viol_ovf, viol_addr_q, viol_pc_q, viol_cnt} !== {1'b1, 1'b1, 1'b1, 16'h00C8, 16'hE010, 8'd2}) begin
            failures++;
            $display("FAIL ovf_log: sys=%b valid=%b ovf=%b addr=%h pc=%h cnt=%0d required 1 1 1 00c8 e010 2",
                     sys_rst, viol_valid, viol_ovf, viol_addr_q, viol_pc_q, viol_cnt);
        end
        tb_ack = 1;
        step();
        tb_ack = 0;
        checks++;
        if ({viol_valid, viol_ovf, viol_addr_q} !== {1'b0, 1'b0, 16'h00C8}) begin
            failures++;
            $display("FAIL ack_clear: valid=%b ovf=%b addr=%h required 0 0 00c8", viol_valid, viol_ovf, viol_addr_q);
        end
        wait_rearm();
    endtask

    task automatic test_stuck();
        int hi;
        do_reset();
        tb_req = 1; tb_addr = 16'h0042; tb_pc = 16'h1000;
        hi = 0;
        repeat (40) begin step(); if (sys_rst === 1'b1) hi++; end
        checks++;
        if (hi != RSTC || sys_rst !== 1'b0 || viol_cnt !== 8'd1) begin
            failures++;
            $display("FAIL stuck_pulse: high=%0d sys=%b cnt=%0d required %0d 0 1", hi, sys_rst, viol_cnt, RSTC);
        end
        tb_req = 0;
        repeat (4) step();
        checks++;
        if (sys_rst !== 1'b0) begin
            failures++; $display("FAIL stuck_quiet: sys_rst=%b required 0", sys_rst);
        end
        tb_req = 1;
        step();
        tb_req = 0;
        checks++;
        if (sys_rst !== 1'b1 || viol_cnt !== 8'd2) begin
            failures++; $display("FAIL stuck_rearm: sys=%b cnt=%0d required 1 2", sys_rst, viol_cnt);
        end
        wait_rearm();
    endtask

    task automatic test_disable();
        int hi;
        do_reset();
        tb_dd = 1; tb_req = 1;
        repeat (5) step();
        checks++;
        if (sys_rst !== 1'b0 || viol_cnt !== 8'd0 || viol_valid !== 1'b0) begin
            failures++;
            $display("FAIL disable_ignore: sys=%b cnt=%0d valid=%b required 0 0 0", sys_rst, viol_cnt, viol_valid);
        end
        tb_dd = 0;
        step();
        tb_req = 0;
        hi = (sys_rst === 1'b1) ? 1 : 0;
        repeat (4) begin step(); if (sys_rst === 1'b1) hi++; end
        tb_dd = 1;
        step();
        checks++;
        if (sys_rst !== 1'b0 || hi != 5 || viol_cnt !== 8'd1) begin
            failures++;
            $display("FAIL disable_abort: sys=%b high=%0d cnt=%0d required 0 5 1", sys_rst, hi, viol_cnt);
        end
        tb_dd = 0;
        wait_rearm();
    endtask

    task automatic test_ack_capture();
        do_reset();
        tb_req = 1; tb_addr = 16'h0111; tb_pc = 16'h2222;
        step();
        tb_req = 0;
        wait_rearm();
        tb_req = 1; tb_ack = 1; tb_addr = 16'h0333; tb_pc = 16'h4444;
        step();
        tb_req = 0; tb_ack = 0;
        checks++;
        if ({viol_valid, viol_ovf, viol_addr_q, viol_pc_q, viol_cnt} !== {1'b1, 1'b0, 16'h0333, 16'h4444, 8'd2}) begin
            failures++;
            $display("FAIL ack_capture: valid=%b ovf=%b addr=%h pc=%h cnt=%0d required 1 0 0333 4444 2",
                     viol_valid, viol_ovf, viol_addr_q, viol_pc_q, viol_cnt);
        end
        wait_rearm();
    endtask

    task automatic test_third();
        int hi;
        int bad;
        do_reset();
        for (int k = 0; k < 2; k++) begin
            tb_req = 1; step(); tb_req = 0;
            wait_rearm();
        end
        tb_req = 1; step(); tb_req = 0;
`ifdef SMART_VIOL_LOCK_EN
        bad = 0;
        repeat (1000) begin
            tb_dd = 1'($urandom_range(0, 1));
            step();
            if (sys_rst !== 1'b1 || locked !== 1'b1) bad++;
        end
        tb_dd = 0;
        checks++;
        if (bad != 0) begin
            failures++; $display("FAIL lock_hold: bad cycles=%0d required 0", bad);
        end
        puc_rst = 1; #2;
        checks++;
        if (sys_rst !== 1'b0 || locked !== 1'b0 || viol_cnt !== '0) begin
            failures++; $display("FAIL lock_clear: sys=%b locked=%b cnt=%0d required 0 0 0", sys_rst, locked, viol_cnt);
        end
        do_reset();
        hi = 0;
`else
        bad = 0;
        hi = (sys_rst === 1'b1) ? 1 : 0;
        repeat (30) begin step(); if (sys_rst === 1'b1) hi++; if (locked !== 1'b0) bad++; end
        checks++;
        if (hi != RSTC || bad != 0 || viol_cnt !== 8'd3) begin
            failures++;
            $display("FAIL third_pulse: high=%0d lockedcycles=%0d cnt=%0d required %0d 0 3", hi, bad, viol_cnt, RSTC);
        end
        wait_rearm();
`endif
    endtask

    task automatic test_saturate();
`ifndef SMART_VIOL_LOCK_EN
        do_reset();
        repeat (MAXC + 5) begin
            tb_req = 1; step(); tb_req = 0;
            wait_rearm();
        end
        checks++;
        if (viol_cnt !== 8'(MAXC)) begin
            failures++; $display("FAIL saturate: cnt=%0d required %0d", viol_cnt, MAXC);
        end
`endif
    endtask

    task automatic test_random();
        logic [43:0] act;
        logic [43:0] exp;
        int          shown;
        do_reset();
        shown = 0;
        for (int c = 0; c < 4000; c++) begin
            tb_req  = ($urandom_range(0, 99) < 35);
            tb_dd   = ($urandom_range(0, 99) < 8);
            tb_ack  = ($urandom_range(0, 99) < 10);
            tb_addr = 16'($urandom);
            tb_pc   = 16'($urandom);
            step();
            act = {sys_rst, viol_valid, viol_ovf, viol_addr_q, viol_pc_q, viol_cnt, locked};
            exp = {m_sys, m_valid, m_ovf, m_addr, m_pc, 8'(m_cnt), m_locked};
            checks++;
            if (act !== exp) begin
                failures++;
                if (shown < 10) begin
                    shown++;
                    $display("FAIL random_cycle%0d: got %h required %h", c, act, exp);
                end
            end
        end
        tb_req = 0; tb_dd = 0; tb_ack = 0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single();
        test_overflow_ack();
        test_stuck();
        test_disable();
        test_ack_capture();
        test_third();
        test_saturate();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
